adjust_pulse_gen: RTL and testbench



---
 rtl/adjust_pulse_gen_pkg.sv | 13 +
 rtl/button_debouncer.sv | 36 +++
 rtl/adjust_pulse_gen.sv | 76 +++++++
 tb/tb_adjust_pulse_gen.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/adjust_pulse_gen_pkg.sv
// adjust_pulse_gen_pkg: shared FSM states, direction codes and helpers for the adjust pulse generator
package adjust_pulse_gen_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE      = 2'd0;
  localparam state_t WAIT_HOLD = 2'd1;
  localparam state_t REPEAT    = 2'd2;
  localparam state_t LOCKOUT   = 2'd3;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchroniser, tick-qualified debounce and one-cycle press edge
module button_debouncer #(
  parameter int DB_N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DB_N + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic s, s_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      s    <= 1'b0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      s_d  <= s;
      if (tick) begin
        if (sync[1] == s) cnt <= '0;
        else if (cnt == CW'(DB_N - 1)) begin
          s   <= sync[1];
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
  end
  assign level = s;
  assign press = s & ~s_d;
endmodule

// File: rtl/adjust_pulse_gen.sv
// adjust_pulse_gen: turns debounced set buttons into count-enable pulses with hold auto-repeat
module adjust_pulse_gen
  import adjust_pulse_gen_pkg::*;
#(
  parameter int DB_N       = 4,
  parameter int HOLD_TICKS = 50,
  parameter int REP_TICKS  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic adj_en,
  input  logic btn_up,
  input  logic btn_down,
  output logic en,
  output logic upDown,
  output logic held
);
  localparam int MAXT = max_int(HOLD_TICKS, REP_TICKS);
  localparam int CW = $clog2(MAXT + 1);
  logic s_up, s_dn, p_up, p_dn;
  logic lat, opp, go_up, go_dn, hit;
  logic [CW-1:0] cnt, cnt_inc;
  state_t state;
  button_debouncer #(.DB_N(DB_N)) u_up (
    .clk(clk), .rst(rst), .tick(tick), .btn(btn_up), .level(s_up), .press(p_up)
  );
  button_debouncer #(.DB_N(DB_N)) u_dn (
    .clk(clk), .rst(rst), .tick(tick), .btn(btn_down), .level(s_dn), .press(p_dn)
  );
  always_comb begin
    cnt_inc = (cnt == CW'(MAXT)) ? cnt : cnt + 1'b1;
    lat     = upDown ? s_dn : s_up;
    opp     = upDown ? s_up : s_dn;
    go_up   = adj_en & p_up & ~s_dn;
    go_dn   = adj_en & p_dn & ~s_up;
    hit     = tick & (cnt_inc == CW'(state == WAIT_HOLD ? HOLD_TICKS : REP_TICKS));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      en     <= 1'b0;
      upDown <= DIR_UP;
      held   <= 1'b0;
    end else begin
      en <= 1'b0;
      case (state)
        IDLE:
          if (go_up | go_dn) begin
            en     <= 1'b1;
            upDown <= go_dn ? DIR_DOWN : DIR_UP;
            cnt    <= '0;
            held   <= 1'b1;
            state  <= WAIT_HOLD;
          end else if (s_up & s_dn) state <= LOCKOUT;
        WAIT_HOLD, REPEAT:
          if (!lat || !adj_en) begin
            held  <= 1'b0;
            state <= IDLE;
          end else if (opp) begin
            held  <= 1'b0;
            state <= LOCKOUT;
          end else if (tick) begin
            cnt <= hit ? '0 : cnt_inc;
            if (hit) begin
              en    <= 1'b1;
              state <= REPEAT;
            end
          end
        default:
          if (!s_up && !s_dn) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adjust_pulse_gen.sv
// tb_adjust_pulse_gen: scoreboard bench for adjust_pulse_gen with directed button scenarios
module tb_adjust_pulse_gen;
  import adjust_pulse_gen_pkg::*;
  logic clk = 0, rst = 1, tick = 0, adj_en = 1, btn_up = 0, btn_down = 0;
  logic en, upDown, held;
  int checks = 0, fails = 0, pulses = 0, ticks_seen = 0, phase = 0, p0;
  logic exp_q[$];
  logic rst_q = 1, en_prev = 0, ud_prev = 0;

  adjust_pulse_gen #(.DB_N(2), .HOLD_TICKS(4), .REP_TICKS(2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .adj_en(adj_en), .btn_up(btn_up),
    .btn_down(btn_down), .en(en), .upDown(upDown), .held(held)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tick = (phase == 0);
    phase = (phase + 1) % 4;
  end

  always @(posedge clk) begin
    rst_q <= rst;
    if (tick && !rst) ticks_seen <= ticks_seen + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int t0 = ticks_seen;
    while (ticks_seen < t0 + n) @(negedge clk);
  endtask

  task automatic end_scn(input string name, input int expn);
    check({name, "_pulses"}, pulses - p0, expn);
    check({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  // monitor: pops the scoreboard on every pulse and enforces the output invariants
  always @(negedge clk) begin
    if (!rst_q) begin
      if (en) begin
        check("en_consecutive", en_prev, 0);
        pulses++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_pulse: got en=1 upDown=%0d expected no pulse", upDown);
        end else check("pulse_dir", upDown, exp_q.pop_front());
      end else check("updown_stable", upDown, ud_prev);
    end
    en_prev = en;
    ud_prev = upDown;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_en", en, 0);
    check("reset_updown", upDown, 0);
    check("reset_held", held, 0);
    rst = 0;
    wait_ticks(1);
    // bounce then settle
    p0 = pulses;
    btn_up = 1; wait_ticks(1);
    btn_up = 0; wait_ticks(1);
    btn_up = 1; wait_ticks(1);
    btn_up = 0; wait_ticks(1);
    check("bounce_no_pulse", pulses - p0, 0);
    exp_q.push_back(DIR_UP);
    btn_up = 1; wait_ticks(2);
    btn_up = 0; wait_ticks(4);
    check("bounce_held", held, 0);
    end_scn("bounce", 1);
    // auto-repeat on down
    p0 = pulses;
    repeat (5) exp_q.push_back(DIR_DOWN);
    btn_down = 1; wait_ticks(2);
    wait_ticks(9);
    check("repeat_held", held, 1);
    btn_down = 0; wait_ticks(3);
    check("repeat_released_held", held, 0);
    end_scn("repeat", 5);
    // conflict lockout
    p0 = pulses;
    exp_q.push_back(DIR_UP);
    exp_q.push_back(DIR_UP);
    btn_up = 1; wait_ticks(2);
    wait_ticks(3);
    btn_down = 1; wait_ticks(3);
    check("conflict_state", dut.state, LOCKOUT);
    check("conflict_held", held, 0);
    btn_up = 0; wait_ticks(3);
    check("conflict_one_released", dut.state, LOCKOUT);
    btn_down = 0; wait_ticks(3);
    check("conflict_both_released", dut.state, IDLE);
    end_scn("conflict", 2);
    // mode gating
    p0 = pulses;
    adj_en = 0;
    btn_up = 1; wait_ticks(3);
    btn_up = 0; wait_ticks(3);
    btn_up = 1; wait_ticks(3);
    adj_en = 1; wait_ticks(3);
    check("gated_no_pulse", pulses - p0, 0);
    btn_up = 0; wait_ticks(3);
    exp_q.push_back(DIR_UP);
    btn_up = 1; wait_ticks(3);
    btn_up = 0; wait_ticks(3);
    end_scn("gating", 1);
    // reset in REPEAT
    p0 = pulses;
    exp_q.push_back(DIR_UP);
    exp_q.push_back(DIR_UP);
    btn_up = 1; wait_ticks(2);
    wait_ticks(5);
    check("pre_reset_held", held, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_en", en, 0);
    check("midrst_held", held, 0);
    check("midrst_updown", upDown, 0);
    check("midrst_state", dut.state, IDLE);
    exp_q.push_back(DIR_UP);
    wait_ticks(3);
    btn_up = 0; wait_ticks(3);
    end_scn("reset", 3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
